// File: rtl/matrix_loader.sv
// matrix_loader: assembles an NxN matrix of signed fixed-point elements, received one
// per cycle over a valid/ready stream in row-major order, and holds it for the
// inverse engine until acknowledged.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   in_data carries an element this cycle
//   in_data    element value (DW bits, stored verbatim)
//   in_ready   loader can accept an element (decoded from state only)
//   clear      synchronous abort of any partial or held matrix
//   mat_out    assembled matrix; element k at [(k+1)*DW-1 : k*DW]
//   mat_valid  mat_out is complete and stable
//   mat_ack    inverse engine has taken mat_out (single-cycle pulse)
//   zero_diag  some diagonal element is zero; meaningful with mat_valid
//   mat_count  matrices acknowledged since reset, wraps at 256
module matrix_loader #(
   parameter int N  = 3,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   input  logic                 clear,
   output logic [N*N*DW-1:0]    mat_out,
   output logic                 mat_valid,
   input  logic                 mat_ack,
   output logic                 zero_diag,
   output logic [7:0]           mat_count
);

   localparam int NE = N * N;
   localparam int IW = $clog2(NE);

   localparam logic StLoad = 1'b0;
   localparam logic StHold = 1'b1;

   logic              state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NE*DW-1:0]  mat_q, mat_d;
   logic              zd_q, zd_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              xfer, is_diag, is_last, el_zero;

   assign in_ready = (state_q == StLoad);
   assign xfer     = in_valid & in_ready;
   assign is_last  = (idx_q == IW'(NE - 1));
   assign el_zero  = (in_data == '0);

   // Diagonal elements sit at k = i*(N+1).
   always_comb begin
      is_diag = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IW'(i * (N + 1))) is_diag = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mat_d   = mat_q;
      zd_d    = zd_q;
      cnt_d   = cnt_q;
      if (clear) begin
         // Storage is left alone; only control state is abandoned.
         state_d = StLoad;
         idx_d   = '0;
         zd_d    = 1'b0;
      end else if (state_q == StLoad) begin
         if (xfer) begin
            mat_d[int'(idx_q) * DW +: DW] = in_data;
            // Element 0 is diagonal and starts a fresh OR-accumulation.
            if (idx_q == '0) begin
               zd_d = el_zero;
            end else if (is_diag) begin
               zd_d = zd_q | el_zero;
            end
            if (is_last) begin
               idx_d   = '0;
               state_d = StHold;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end else if (mat_ack) begin
         state_d = StLoad;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StLoad;
         idx_q   <= '0;
         mat_q   <= '0;
         zd_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mat_q   <= mat_d;
         zd_q    <= zd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mat_out   = mat_q;
   assign mat_valid = (state_q == StHold);
   assign zero_diag = zd_q;
   assign mat_count = cnt_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed stimulus for matrix_loader with a behavioural model
// (element array, fill count, hold flag, delivery count) checked every cycle,
// plus literal expectations at key points.
module tb_matrix_loader;

   localparam int N  = 3;
   localparam int DW = 16;
   localparam int NE = N * N;
   localparam int MW = NE * DW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [DW-1:0]  in_data = '0;
   logic           in_ready;
   logic           clear = 1'b0;
   logic [MW-1:0]  mat_out;
   logic           mat_valid;
   logic           mat_ack = 1'b0;
   logic           zero_diag;
   logic [7:0]     mat_count;

   int tests = 0;
   int fails = 0;
   bit done  = 1'b0;

   // Model state
   logic [DW-1:0] m [NE];
   int            fill    = 0;
   bit            holding = 1'b0;
   int            count   = 0;

   matrix_loader #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .clear     (clear),
      .mat_out   (mat_out),
      .mat_valid (mat_valid),
      .mat_ack   (mat_ack),
      .zero_diag (zero_diag),
      .mat_count (mat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [MW-1:0] model_mat();
      logic [MW-1:0] v;
      for (int k = 0; k < NE; k++) v[k*DW +: DW] = m[k];
      return v;
   endfunction

   function automatic logic model_zd();
      logic z = 1'b0;
      for (int i = 0; i < N; i++) if (m[i*(N+1)] == '0) z = 1'b1;
      return z;
   endfunction

   function automatic logic [MW-1:0] seq_mat(input int base);
      logic [MW-1:0] v;
      for (int k = 0; k < NE; k++) v[k*DW +: DW] = DW'(base + k);
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NE; k++) m[k] = '0;
      fill    = 0;
      holding = 1'b0;
      count   = 0;
   endtask

   // Model: updated on each clock edge from the inputs held since the previous edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else if (clear) begin
            fill    = 0;
            holding = 1'b0;
         end else if (!holding) begin
            if (in_valid) begin
               m[fill] = in_data;
               fill++;
               if (fill == NE) begin
                  fill    = 0;
                  holding = 1'b1;
               end
            end
         end else if (mat_ack) begin
            holding = 1'b0;
            count   = (count + 1) % 256;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (done) break;
         if (!rst) begin
            check("in_ready", MW'(in_ready), MW'(!holding));
            check("mat_valid", MW'(mat_valid), MW'(holding));
            check("mat_count", MW'(mat_count), MW'(count));
            if (holding) begin
               check("mat_out", mat_out, model_mat());
               check("zero_diag", MW'(zero_diag), MW'(model_zd()));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stream(input int base, input int zero_at);
      for (int k = 0; k < NE; k++) begin
         in_valid = 1'b1;
         in_data  = (k == zero_at) ? '0 : DW'(base + k);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic ack();
      mat_ack = 1'b1;
      step();
      mat_ack = 1'b0;
   endtask

   initial begin
      logic [MW-1:0] snap;
      step();
      step();
      rst = 1'b0;
      check("reset in_ready", MW'(in_ready), MW'(1));
      check("reset mat_valid", MW'(mat_valid), MW'(0));
      check("reset mat_count", MW'(mat_count), MW'(0));
      check("reset zero_diag", MW'(zero_diag), MW'(0));
      check("reset mat_out", mat_out, '0);

      // 1: stream 1..9 with in_valid held high
      stream(1, -1);
      check("t1 mat_valid", MW'(mat_valid), MW'(1));
      check("t1 elem0", MW'(mat_out[15:0]), MW'(1));
      check("t1 elem8", MW'(mat_out[143:128]), MW'(9));
      check("t1 zero_diag", MW'(zero_diag), MW'(0));
      check("t1 in_ready", MW'(in_ready), MW'(0));

      // 2: hold 20 cycles with in_valid asserted, then ack
      snap = seq_mat(1);
      in_valid = 1'b1;
      in_data  = 16'hdead;
      for (int c = 0; c < 20; c++) step();
      in_valid = 1'b0;
      check("t2 held mat_out", mat_out, snap);
      check("t2 held mat_valid", MW'(mat_valid), MW'(1));
      ack();
      check("t2 ack mat_valid", MW'(mat_valid), MW'(0));
      check("t2 ack in_ready", MW'(in_ready), MW'(1));
      check("t2 ack mat_count", MW'(mat_count), MW'(1));

      // 3: zero on diagonal element 4, then a clean matrix
      stream(10, 4);
      check("t3 zero_diag set", MW'(zero_diag), MW'(1));
      check("t3 elem4", MW'(mat_out[79:64]), MW'(0));
      ack();
      stream(20, -1);
      check("t3 zero_diag clr", MW'(zero_diag), MW'(0));
      ack();
      // zero off the diagonal must not flag
      stream(30, 1);
      check("t3 offdiag zero", MW'(zero_diag), MW'(0));
      ack();
      check("t3 mat_count", MW'(mat_count), MW'(4));

      // 4: clear after 5 transfers, then 9 new elements
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = DW'(100 + k);
         step();
      end
      in_valid = 1'b0;
      clear    = 1'b1;
      step();
      clear = 1'b0;
      check("t4 clear mat_valid", MW'(mat_valid), MW'(0));
      stream(200, -1);
      check("t4 new mat_out", mat_out, seq_mat(200));
      ack();
      // clear together with the 9th element drops it
      for (int k = 0; k < NE; k++) begin
         in_valid = 1'b1;
         in_data  = DW'(400 + k);
         clear    = (k == NE - 1);
         step();
      end
      clear    = 1'b0;
      in_valid = 1'b0;
      step();
      check("t4 clear9 mat_valid", MW'(mat_valid), MW'(0));
      check("t4 clear9 in_ready", MW'(in_ready), MW'(1));
      stream(300, -1);
      check("t4 restart mat_valid", MW'(mat_valid), MW'(1));
      check("t4 restart mat_out", mat_out, seq_mat(300));
      ack();
      check("t4 mat_count", MW'(mat_count), MW'(6));

      // 5: clear and ack together in HOLD, then wrap the counter
      stream(500, -1);
      mat_ack = 1'b1;
      clear   = 1'b1;
      step();
      mat_ack = 1'b0;
      clear   = 1'b0;
      check("t5 clr+ack mat_valid", MW'(mat_valid), MW'(0));
      check("t5 clr+ack mat_count", MW'(mat_count), MW'(6));
      for (int j = 0; j < 250; j++) begin
         stream(j * 3 + 1, -1);
         ack();
      end
      check("t5 wrap mat_count", MW'(mat_count), MW'(0));
      stream(700, -1);
      ack();
      check("t5 post-wrap mat_count", MW'(mat_count), MW'(1));

      // 6: asynchronous reset mid-fill
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = DW'(800 + k);
         step();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("t6 async mat_valid", MW'(mat_valid), MW'(0));
      check("t6 async in_ready", MW'(in_ready), MW'(1));
      check("t6 async mat_count", MW'(mat_count), MW'(0));
      check("t6 async mat_out", mat_out, '0);
      step();
      rst = 1'b0;
      stream(900, -1);
      check("t6 fresh mat_valid", MW'(mat_valid), MW'(1));
      check("t6 fresh mat_out", mat_out, seq_mat(900));
      ack();
      check("t6 fresh mat_count", MW'(mat_count), MW'(1));

      step();
      done = 1'b1;
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
